// File: rtl/rr_dispatch_pkg.sv
// Shared constants and helpers for the round-robin dispatcher.
// Helpers operate on MAX_N-wide vectors so any sink count up to MAX_N can use them.
package rr_dispatch_pkg;

  localparam int STATS_W = 16;
  localparam int MAX_N   = 32;

  function automatic int onehot_to_idx(input logic [MAX_N-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  // Rotate the low n bits left by one; bit n-1 wraps to bit 0.
  function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] v, input int n);
    logic [MAX_N-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n && v[i]) r[(i + 1 == n) ? 0 : i + 1] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set bit of free at or above the
// pointer position, wrapping, found by scanning a doubled copy of free.
module rr_pick
  import rr_dispatch_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  free,
  input  logic [N-1:0]  ptr_onehot,
  output logic [N-1:0]  pick_onehot,
  output logic [IW-1:0] pick_idx,
  output logic          any
);

  logic [2*N-1:0] dbl;
  int             ptr_pos;

  always_comb begin
    dbl         = {free, free};
    ptr_pos     = onehot_to_idx(MAX_N'(ptr_onehot));
    pick_onehot = '0;
    pick_idx    = '0;
    any         = 1'b0;
    for (int j = 0; j < 2 * N; j++) begin
      if (!any && j >= ptr_pos && dbl[j]) begin
        any = 1'b1;
        pick_idx = IW'((j >= N) ? j - N : j);
        pick_onehot[(j >= N) ? j - N : j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_dispatcher.sv
// 1-to-N round-robin stream dispatcher with a one-entry register per sink.
// Optional per-sink saturating dispatch counters when RR_DISPATCHER_STATS_EN is defined.
module rr_dispatcher
  import rr_dispatch_pkg::*;
#(
  parameter int NUM_SINKS = 4,
  parameter int DATA_W    = 32,
  localparam int IW = $clog2(NUM_SINKS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_W-1:0]           s_data,
  output logic [NUM_SINKS-1:0]        m_valid,
  input  logic [NUM_SINKS-1:0]        m_ready,
  output logic [NUM_SINKS*DATA_W-1:0] m_data,
  output logic [IW-1:0]               last_sink
`ifdef RR_DISPATCHER_STATS_EN
  ,
  input  logic                         stats_clr,
  output logic [NUM_SINKS*STATS_W-1:0] dispatch_cnt
`endif
);

  // Handshakes: a word moves when valid & ready are both high at a rising clk edge.
  // s_ready reflects slot availability only (never s_valid); it depends
  // combinationally on m_ready because a draining slot can be refilled at once.
  logic [NUM_SINKS-1:0] free;
  logic [NUM_SINKS-1:0] ptr;
  logic [NUM_SINKS-1:0] pick_onehot;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic                 fire;

  assign free    = ~m_valid | m_ready;
  assign s_ready = |free;
  assign fire    = s_valid & s_ready;

  rr_pick #(.N(NUM_SINKS)) u_pick (
    .free        (free),
    .ptr_onehot  (ptr),
    .pick_onehot (pick_onehot),
    .pick_idx    (pick_idx),
    .any         (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid   <= '0;
      m_data    <= '0;
      last_sink <= '0;
      ptr       <= NUM_SINKS'(1);
    end else begin
      for (int i = 0; i < NUM_SINKS; i++) begin
        if (fire && pick_any && pick_onehot[i]) begin
          m_valid[i]                     <= 1'b1;
          m_data[i*DATA_W +: DATA_W]     <= s_data;
        end else if (m_ready[i]) begin
          m_valid[i] <= 1'b0;
        end
      end
      // Pointer only advances on a dispatch, so idle cycles keep the rotation point.
      if (fire) begin
        last_sink <= pick_idx;
        ptr       <= NUM_SINKS'(rotl1(MAX_N'(pick_onehot), NUM_SINKS));
      end
    end
  end

`ifdef RR_DISPATCHER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dispatch_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_SINKS; i++) begin
        if (stats_clr) begin
          dispatch_cnt[i*STATS_W +: STATS_W] <= '0;
        end else if (fire && pick_onehot[i] && dispatch_cnt[i*STATS_W +: STATS_W] != '1) begin
          dispatch_cnt[i*STATS_W +: STATS_W] <= dispatch_cnt[i*STATS_W +: STATS_W] + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_rr_dispatcher.sv
// Directed + random bench for rr_dispatcher with a reference model and expected queue.
// Defining RR_DISPATCHER_STATS_EN adds the 2-sink counter saturation test.
module tb_rr_dispatcher;

  logic         clk;
  logic         rst_n;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic [3:0]   m_valid;
  logic [3:0]   m_ready;
  logic [127:0] m_data;
  logic [1:0]   last_sink;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [3:0]  mv;
  logic [31:0] md [4];
  int          mptr;

  logic [33:0] exp_q[$];

`ifdef RR_DISPATCHER_STATS_EN
  logic         stats_clr;
  logic [63:0]  dispatch_cnt;
  logic         s_valid2;
  logic         s_ready2;
  logic [31:0]  s_data2;
  logic [1:0]   m_valid2;
  logic [1:0]   m_ready2;
  logic [63:0]  m_data2;
  logic         last_sink2;
  logic         stats_clr2;
  logic [31:0]  dispatch_cnt2;
`endif

  rr_dispatcher #(.NUM_SINKS(4), .DATA_W(32)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .last_sink (last_sink)
`ifdef RR_DISPATCHER_STATS_EN
    ,
    .stats_clr    (stats_clr),
    .dispatch_cnt (dispatch_cnt)
`endif
  );

`ifdef RR_DISPATCHER_STATS_EN
  rr_dispatcher #(.NUM_SINKS(2), .DATA_W(32)) u_dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid2),
    .s_ready      (s_ready2),
    .s_data       (s_data2),
    .m_valid      (m_valid2),
    .m_ready      (m_ready2),
    .m_data       (m_data2),
    .last_sink    (last_sink2),
    .stats_clr    (stats_clr2),
    .dispatch_cnt (dispatch_cnt2)
  );
`endif

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mv   = '0;
    mptr = 0;
    for (int i = 0; i < 4; i++) md[i] = '0;
  endtask

  // Asserts reset between clock edges, checks the asynchronous clear, releases on a negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_m_valid", 128'(m_valid), 128'(0));
    chk("rst_m_data", m_data, 128'(0));
    chk("rst_last_sink", 128'(last_sink), 128'(0));
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Driver: one cycle of stimulus applied at negedge, outputs checked at the following negedge.
  task automatic step(input logic v, input logic [31:0] d, input logic [3:0] rdy);
    logic [3:0]  fr;
    logic        fire;
    int          pick;
    logic [33:0] e;
    logic [127:0] md_flat;
    s_valid = v;
    s_data  = d;
    m_ready = rdy;
    #1;
    fr = ~mv | rdy;
    chk("s_ready", 128'(s_ready), 128'(|fr));
    fire = v & (|fr);
    pick = -1;
    if (fire) begin
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (mptr + k) % 4;
        if (pick < 0 && fr[idx]) pick = idx;
      end
      exp_q.push_back({2'(pick), d});
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (fire && i == pick) begin
        mv[i] = 1'b1;
        md[i] = d;
      end else if (rdy[i]) begin
        mv[i] = 1'b0;
      end
    end
    if (fire) mptr = (pick + 1) % 4;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pick_m_valid", 128'(m_valid[e[33:32]]), 128'(1));
      chk("pick_m_data", 128'(m_data[e[33:32]*32 +: 32]), 128'(e[31:0]));
      chk("last_sink", 128'(last_sink), 128'(e[33:32]));
    end
    md_flat = {md[3], md[2], md[1], md[0]};
    chk("m_valid", 128'(m_valid), 128'(mv));
    chk("m_data_all", m_data, md_flat);
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = '0;
`ifdef RR_DISPATCHER_STATS_EN
    stats_clr  = 1'b0;
    s_valid2   = 1'b0;
    s_data2    = '0;
    m_ready2   = '0;
    stats_clr2 = 1'b0;
`endif
    model_reset();
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // 1: back-to-back words, all sinks ready
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'h10 + 32'(i), 4'b1111);
      chk("t1_sink", 128'(last_sink), 128'(i % 4));
    end
    step(1'b0, 32'h0, 4'b1111);

    // 2: sink 1 stalled with a word, pointer left at 1
    for (int i = 0; i < 5; i++) step(1'b1, 32'h50 + 32'(i), 4'b1101);
    chk("t2_ptr_setup", 128'(last_sink), 128'(0));
    step(1'b1, 32'hA0, 4'b1101); chk("t2_a0", 128'(last_sink), 128'(2));
    step(1'b1, 32'hA1, 4'b1101); chk("t2_a1", 128'(last_sink), 128'(3));
    step(1'b1, 32'hA2, 4'b1101); chk("t2_a2", 128'(last_sink), 128'(0));
    step(1'b1, 32'hA3, 4'b1101); chk("t2_a3", 128'(last_sink), 128'(2));
    chk("t2_sink1_stable", 128'(m_data[63:32]), 128'(32'h51));

    // 3: all stalled, fifth word waits, then refills draining sink 2 with no bubble
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 32'hC0 + 32'(i), 4'b0000);
    chk("t3_full", 128'(m_valid), 128'(4'hF));
    step(1'b1, 32'hC4, 4'b0000);
    chk("t3_held", 128'(m_data[95:64]), 128'(32'hC2));
    step(1'b1, 32'hC4, 4'b0100);
    chk("t3_refill_sink", 128'(last_sink), 128'(2));
    chk("t3_refill_data", 128'(m_data[95:64]), 128'(32'hC4));

    // 4: pointer at 3, idle gap, wrap to sink 0
    step(1'b0, 32'h0, 4'b1111);
    step(1'b1, 32'hB0, 4'b1111);
    chk("t4_first", 128'(last_sink), 128'(3));
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 4'b1111);
    step(1'b1, 32'hB1, 4'b1111);
    chk("t4_wrap", 128'(last_sink), 128'(0));

    // Random traffic against the model
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
    end

    // 5: reset while every slot is full
    step(1'b0, 32'h0, 4'b1111);
    for (int i = 0; i < 4; i++) step(1'b1, 32'hD0 + 32'(i), 4'b0000);
    chk("t5_full", 128'(m_valid), 128'(4'hF));
    do_reset();
    step(1'b1, 32'hE0, 4'b1111);
    chk("t5_after_reset", 128'(last_sink), 128'(0));

`ifdef RR_DISPATCHER_STATS_EN
    // 6: 2-sink counters; sink 1 held busy so every further word lands in sink 0
    s_valid = 1'b0;
    s_valid2 = 1'b1;
    s_data2  = 32'h77;
    m_ready2 = 2'b00;
    @(negedge clk);
    m_ready2 = 2'b01;
    @(negedge clk);
    chk("t6_seed", 128'(dispatch_cnt2), 128'(32'h0001_0001));
    for (int i = 0; i < 100; i++) @(negedge clk);
    chk("t6_count", 128'(dispatch_cnt2), 128'(32'h0001_0065));
    for (int i = 0; i < 69900; i++) @(negedge clk);
    chk("t6_saturate", 128'(dispatch_cnt2), 128'(32'h0001_FFFF));
    stats_clr2 = 1'b1;
    @(negedge clk);
    stats_clr2 = 1'b0;
    chk("t6_clear", 128'(dispatch_cnt2), 128'(0));
    @(negedge clk);
    chk("t6_after_clear", 128'(dispatch_cnt2), 128'(32'h0000_0001));
    s_valid2 = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_dispatcher.md
Name: rr_dispatcher

Overview:
- Splits one valid/ready stream across NUM_SINKS consumers in round-robin order. It is the 1→N counterpart of the N→1 round-robin arbiter.
- Each sink has a one-entry output register. Round-robin selection skips any sink whose slot is occupied and not draining.
- Sits between a shared producer, such as a command queue, and parallel worker engines.

Parameters:
- NUM_SINKS, 4, number of output channels (≥2).
- DATA_W, 32, payload width in bits.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous, active-low reset
- s_valid  input  1  producer word valid
- s_ready  output  1  dispatcher can accept a word this cycle
- s_data  input  DATA_W  producer payload
- m_valid  output  NUM_SINKS  per-sink slot holds a word
- m_ready  input  NUM_SINKS  per-sink consumer accepts
- m_data  output  NUM_SINKS*DATA_W  per-sink payload; sink i occupies bits [i*DATA_W +: DATA_W]
- last_sink  output  $clog2(NUM_SINKS)  index of the sink that received the most recent dispatched word

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous, active-low.
- Reset state:
  - m_valid = 0.
  - m_data = 0.
  - last_sink = 0.
  - Priority pointer = one-hot bit 0 (sink 0 has first priority).
- Slot state:
  - free[i] = ~m_valid[i] | m_ready[i].
  - This is a combinational path from m_ready to s_ready. It is accepted and must be documented at the integration level.
- s_ready = |free. It does not depend on s_valid.
- Pick: choose the first i with free[i]=1, scanning from the pointer position upward and wrapping modulo NUM_SINKS. At most one sink is chosen per cycle.
- Dispatch fires when s_valid & s_ready. On that clock edge:
  - m_data[pick] <= s_data.
  - m_valid[pick] <= 1.
  - last_sink <= pick.
  - Pointer <= one-hot of (pick+1) mod NUM_SINKS. Wrap-around from NUM_SINKS-1 goes to 0.
- No dispatch (s_valid=0 or all slots busy): the pointer holds. The starting point is not advanced by idle cycles.
- Drain: when m_valid[i] & m_ready[i] and sink i is not picked, m_valid[i] <= 0 and m_data[i] holds its value.
- Simultaneous drain and refill of the same sink: m_valid stays 1 and the new data loads with no bubble.
- Latency: input handshake to m_valid is 1 cycle.
- Throughput: one word per cycle while any slot is free.
- Ordering:
  - Words are issued to sinks in rotating order.
  - Ordering across sinks is not preserved.
  - A busy sink is skipped, not waited for.
- Stability: m_data[i] must not change while m_valid[i]=1 and m_ready[i]=0.
- All busy: s_ready=0. State is unchanged except for drains.
- Reset mid-operation: all in-flight slots are discarded. Outputs and pointer return to reset values immediately (asynchronous assert). Deassertion is synchronous to clk through the standard reset synchroniser.

Optional Feature:
- Macro: RR_DISPATCHER_STATS_EN.
- With the macro defined:
  - Extra output port dispatch_cnt, NUM_SINKS*16 bits.
  - Each per-sink counter increments on each dispatch to that sink and saturates at 16'hFFFF.
  - Counters reset to 0 with rst_n.
  - Extra input stats_clr, 1 bit, synchronous clear. Clear wins over a same-cycle increment.
- Without the macro: neither port exists, no counter logic is generated, and all other behaviour is identical.

Decomposition:
- Package rr_dispatch_pkg holds:
  - STATS_W = 16.
  - Function onehot_to_idx.
  - Function rotl1 (rotate a one-hot vector left by 1 with wrap).
- Sub-module rr_pick: purely combinational rotating-priority picker.
  - Parameter: N.
  - Inputs: free[N], ptr_onehot[N].
  - Outputs: pick_onehot[N], pick_idx, any.
  - Internally it uses a doubled-vector scan.

Test Plan:
1. Reset, then all m_ready=1 and 8 words 0x10..0x17 back-to-back → sinks 0,1,2,3,0,1,2,3 in order. s_ready=1 every cycle, each m_valid rises 1 cycle after its handshake.
2. Sink 1 stalled (m_ready[1]=0) holding a word, others ready, send 0xA0..0xA3 starting with pointer at 1 → words go to sinks 2,3,0,2. m_data[1] remains stable throughout.
3. All m_ready=0, 5 words offered → first 4 fill sinks 0..3. Then s_ready=0 and the 5th word is held. Raise m_ready[2] → 5th word goes to sink 2 in the same cycle with no bubble.
4. Pointer at 3, one dispatch, s_valid low 3 cycles, next dispatch → the first word lands in sink 3 and the next in sink 0. This shows wrap-around and that the pointer holds while idle.
5. Assert rst_n low while all 4 slots are valid → m_valid=0 asynchronously. After release, the first dispatch goes to sink 0.
6. RR_DISPATCHER_STATS_EN defined, 70000 dispatches to a 2-sink config, then stats_clr pulsed on a dispatch cycle → counters saturate at 0xFFFF, then read 0 the cycle after the clear.
